// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter.
// Each frame is a 0 start bit, DATA_W data bits LSB first and a 1 stop bit.
// Every bit lasts CLKS_PER_BIT clocks. Q, QB and done come straight from flops.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  output logic              ready,
  output logic              Q,
  output logic              QB,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               q_q, q_d;
  logic               done_q, done_d;

  logic bit_end;
  logic last_bit;
  logic accept;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign last_bit = (bit_q == BIT_LAST);
  assign accept   = load && (state_q == IDLE);

  // State and datapath registers; reset aborts any frame and forces the idle line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      q_q     <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: each non-idle state advances at the end of its bit period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && last_bit) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs: the line value for the next bit is loaded
  // on the same edge that begins that bit, so Q needs no output decoding.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    q_d     = q_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        q_d   = 1'b1;
        if (accept) begin
          shift_d = data;
          q_d     = 1'b0;
        end
      end
      START: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          bit_d = '0;
          q_d   = shift_q[0];
        end
      end
      DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          if (last_bit) begin
            q_d = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            q_d     = shift_d[0];
          end
        end
      end
      STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        q_d   = 1'b1;
        if (bit_end) done_d = 1'b1;
      end
      default: begin
        cnt_d = '0;
        bit_d = '0;
        q_d   = 1'b1;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign Q     = q_q;
  assign QB    = ~q_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed scoreboard bench for serial_tx.
// Two instances share clk/rst: one with 4 clocks per bit, one with 1.
module tb_serial_tx;

  typedef struct packed {
    logic q;
    logic done;
    logic ready;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] data4 = 8'h00;
  logic       load4 = 1'b0;
  logic       ready4, q4, qb4, done4;

  logic [7:0] data1 = 8'h00;
  logic       load1 = 1'b0;
  logic       ready1, q1, qb1, done1;

  exp_t exp4_q[$];
  exp_t exp1_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .data(data4), .load(load4),
    .ready(ready4), .Q(q4), .QB(qb4), .done(done4)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .data(data1), .load(load1),
    .ready(ready1), .Q(q1), .QB(qb1), .done(done1)
  );

  task automatic check(input string tag, input int cyc, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  // Build the expected per-cycle trace of one frame, starting with the
  // sample taken just after the accepting edge and ending with the done cycle.
  task automatic push_frame(input logic [7:0] d, input int cpb, input bit to_fast);
    exp_t e;
    for (int k = 0; k < cpb; k++) begin
      e = '{q: 1'b0, done: 1'b0, ready: 1'b0};
      if (to_fast) exp1_q.push_back(e); else exp4_q.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < cpb; k++) begin
        e = '{q: d[i], done: 1'b0, ready: 1'b0};
        if (to_fast) exp1_q.push_back(e); else exp4_q.push_back(e);
      end
    end
    for (int k = 0; k < cpb; k++) begin
      e = '{q: 1'b1, done: 1'b0, ready: 1'b0};
      if (to_fast) exp1_q.push_back(e); else exp4_q.push_back(e);
    end
    e = '{q: 1'b1, done: 1'b1, ready: 1'b1};
    if (to_fast) exp1_q.push_back(e); else exp4_q.push_back(e);
  endtask

  int cyc = 0;

  // Advance one clock, sample 1 ns after the edge and compare both instances
  // against the head of their scoreboards (idle values when empty).
  task automatic tick();
    exp_t e4, e1;
    @(posedge clk);
    #1;
    cyc++;
    e4 = (exp4_q.size() > 0) ? exp4_q.pop_front() : '{q: 1'b1, done: 1'b0, ready: 1'b1};
    e1 = (exp1_q.size() > 0) ? exp1_q.pop_front() : '{q: 1'b1, done: 1'b0, ready: 1'b1};
    check("cpb4_Q",     cyc, q4,     e4.q);
    check("cpb4_QB",    cyc, qb4,    ~e4.q);
    check("cpb4_done",  cyc, done4,  e4.done);
    check("cpb4_ready", cyc, ready4, e4.ready);
    check("cpb1_Q",     cyc, q1,     e1.q);
    check("cpb1_QB",    cyc, qb1,    ~e1.q);
    check("cpb1_done",  cyc, done1,  e1.done);
    check("cpb1_ready", cyc, ready1, e1.ready);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset held for two cycles; a load on a reset edge must be dropped.
    rst = 1'b1;
    tick();
    load4 = 1'b1; data4 = 8'hC3;
    load1 = 1'b1; data1 = 8'hC3;
    tick();
    load4 = 1'b0; load1 = 1'b0;
    rst = 1'b0;
    ticks(3);

    // Single frame of A5.
    data4 = 8'hA5; load4 = 1'b1;
    push_frame(8'hA5, 4, 1'b0);
    tick();
    load4 = 1'b0; data4 = 8'h00;
    ticks(44);

    // Frame of 3C with a stray load and data change mid-frame.
    data4 = 8'h3C; load4 = 1'b1;
    push_frame(8'h3C, 4, 1'b0);
    tick();
    load4 = 1'b0;
    ticks(9);
    data4 = 8'hFF; load4 = 1'b1;
    tick();
    load4 = 1'b0;
    ticks(35);

    // Back-to-back: load held high across the done cycle.
    data4 = 8'h01; load4 = 1'b1;
    push_frame(8'h01, 4, 1'b0);
    tick();
    data4 = 8'h80;
    push_frame(8'h80, 4, 1'b0);
    ticks(41);
    load4 = 1'b0; data4 = 8'h00;
    ticks(44);

    // Reset in cycle 17 of a frame, then a load on the first non-reset edge.
    data4 = 8'h96; load4 = 1'b1;
    push_frame(8'h96, 4, 1'b0);
    tick();
    load4 = 1'b0;
    ticks(16);
    rst = 1'b1;
    exp4_q.delete();
    tick();
    rst = 1'b0;
    ticks(3);
    data4 = 8'h5A; load4 = 1'b1;
    push_frame(8'h5A, 4, 1'b0);
    tick();
    load4 = 1'b0;
    ticks(44);

    // One clock per bit: 55, then a back-to-back pair on the fast instance.
    data1 = 8'h55; load1 = 1'b1;
    push_frame(8'h55, 1, 1'b1);
    tick();
    load1 = 1'b0;
    ticks(14);
    data1 = 8'hE1; load1 = 1'b1;
    push_frame(8'hE1, 1, 1'b1);
    tick();
    data1 = 8'h2B;
    push_frame(8'h2B, 1, 1'b1);
    ticks(11);
    load1 = 1'b0;
    ticks(14);

    if (exp4_q.size() != 0 || exp1_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d/%0d entries left expected 0/0",
             exp4_q.size(), exp1_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_W, default 8: width of the parallel word; SHALL be >= 1.
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit period; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 data  input  DATA_W  parallel word to transmit; sampled only on an accepted load.
REQ-006 load  input  1  request to start a frame; accepted when load=1 and ready=1 at a rising edge.
REQ-007 ready  output  1  high when a load will be accepted at the next rising edge.
REQ-008 Q  output  1  serial line; idle level is 1.
REQ-009 QB  output  1  complement of Q at all times.
REQ-010 done  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-011 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, stop bit (1), each bit held exactly CLKS_PER_BIT cycles.
REQ-012 Frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles, with no gap cycles inserted.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; transitions: IDLE->START on accepted load, START->DATA after CLKS_PER_BIT cycles, DATA->STOP after DATA_W bit periods, STOP->IDLE after CLKS_PER_BIT cycles.
REQ-014 On the accepted-load edge, data SHALL be captured into an internal shift register; later changes on data SHALL NOT affect the frame in flight.
REQ-015 Q SHALL go to 0 on the same edge that accepts the load (1-cycle latency from load sampling to start bit).
REQ-016 ready SHALL be 1 only in IDLE and SHALL drop on the accepting edge.
REQ-017 load while ready=0 SHALL be ignored, with no queuing and no effect on the current frame.
REQ-018 A bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; a bit index SHALL count 0..DATA_W-1 in DATA.
REQ-019 On the edge that ends the stop bit, the FSM SHALL enter IDLE with ready=1, Q=1 and done=1; done SHALL clear on the next edge.
REQ-020 Back-to-back frames: a load asserted in the done cycle SHALL be accepted, and the next start bit SHALL follow immediately after the done cycle with no extra idle cycle.
REQ-021 CLKS_PER_BIT=1 SHALL produce one cycle per bit with identical framing.
REQ-022 In IDLE, Q SHALL hold 1 and done SHALL hold 0 indefinitely.
REQ-023 There SHALL be no combinational path from load or data to Q, QB or done; these outputs SHALL be registered.

Reset
REQ-024 With rst=1 at a rising edge, the block SHALL enter IDLE and SHALL set Q=1, QB=0, ready=1, done=0, and clear both counters.
REQ-025 rst SHALL take priority over load; a load on a reset edge SHALL be dropped.
REQ-026 A reset mid-frame SHALL abort the frame: Q=1 after that edge, no done pulse, and the partial word is discarded.
REQ-027 After rst deasserts, a load SHALL be accepted on the first rising edge with rst=0.

Verification (DATA_W=8, CLKS_PER_BIT=4 unless stated)
REQ-028 Reset: hold rst=1 for 2 cycles, then release -> Q=1, QB=0, ready=1, done=0 throughout.
REQ-029 Single frame: load=1 with data=8'hA5 for one cycle -> Q = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; done pulses at cycle 40 after acceptance, with ready=1 in that same cycle.
REQ-030 Ignored load and data change: during a frame of 8'h3C, pulse load with data=8'hFF -> the serialized bits remain 0,0,1,1,1,1,0,0, and no second frame starts.
REQ-031 Back-to-back: keep load=1 with 8'h01 followed by 8'h80 -> two contiguous 40-cycle frames; the second start bit begins the cycle after the first done; done pulses twice.
REQ-032 Reset mid-frame: assert rst in cycle 17 of a frame -> Q=1 and ready=1 on the next edge, no done pulse, and a following load sends a complete, correct frame.
REQ-033 CLKS_PER_BIT=1, data=8'h55 -> 10-cycle frame 0,1,0,1,0,1,0,1,0,1; QB equals ~Q in every cycle.
